mem_arb: RTL
============

# mem_arb

Two-port arbiter and access sequencer for the single 16-bit external cartridge RAM. It shares the RAM between the CPU byte path (address/data register window, 8-bit) and the PI-side DMA path (16-bit words). CPU requests win by default, and a wait counter guarantees DMA progress. The block also generates the registered ce/oe/we/be strobes for each RAM access.

## Interface
Parameters:
- ACC_CYC, 4: cycles ram_ce is held per access; minimum 3.
- RCV_CYC, 1: idle cycles after each access; minimum 1.
- DMA_MAX_WAIT, 16: DMA wait cycles after which DMA overrides CPU priority.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- cpu_req  in  1  level request; held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  23  byte address
- cpu_dati  in  8  write data
- cpu_dato  out  8  read data; valid from cpu_ack, held until the next CPU read ack
- cpu_ack  out  1  one-cycle completion pulse
- dma_req  in  1  level request; held until dma_ack
- dma_we  in  1  1 = write, 0 = read
- dma_addr  in  22  word address
- dma_dati  in  16  write data
- dma_dato  out  16  read data; valid from dma_ack, held until the next DMA read ack
- dma_ack  out  1  one-cycle completion pulse
- ram_addr  out  22  RAM word address
- ram_dati  out  16  RAM write data
- ram_dato  in  16  RAM read data
- ram_ce, ram_oe, ram_we  out  1  RAM strobes, active-high, all registered
- ram_be  out  2  byte enables; bit 1 = [15:8]
- busy  out  1  high in every state other than IDLE

## Operation
- States: IDLE, CPU_ACC, DMA_ACC, RECOV.
- IDLE arbitration, evaluated each cycle:
  - DMA is granted if dma_req and (wait_ctr ≥ DMA_MAX_WAIT or !cpu_req).
  - Otherwise CPU is granted if cpu_req.
- On grant, latch the address, we and write data into internal registers, then enter CPU_ACC or DMA_ACC. Requester inputs are ignored for the rest of the access.
- CPU access:
  - ram_addr = cpu_addr[22:1].
  - ram_be = cpu_addr[0] ? 2'b10 : 2'b01.
  - ram_dati = {cpu_dati, cpu_dati}.
  - Read data = byte selected by the latched addr[0].
- DMA access: ram_be = 2'b11, full word.
- The ACC states run a phase counter 0..ACC_CYC-1:
  - ram_ce is high in all phases.
  - ram_oe is high in all phases for reads.
  - ram_we is high in phases 1..ACC_CYC-2 for writes only, giving one phase of address/data setup and one of hold.
- On the last phase, ram_dato is captured into the requester's dato register (reads only).
- RECOV lasts RCV_CYC cycles:
  - The matching ack pulses in the first RECOV cycle.
  - All RAM strobes are low.
  - Return to IDLE afterwards.
- Requesters deassert req by the edge after ack. Since RCV_CYC ≥ 1, an acked request is never re-granted.
- wait_ctr (6-bit, saturating): increments every cycle dma_req=1 and the DMA is not in DMA_ACC/RECOV; cleared on DMA grant.
- Reset values:
  - state = IDLE; wait_ctr = 0.
  - All strobes = 0; ram_be = 0; acks = 0; busy = 0.
  - cpu_dato = 8'hFF; dma_dato = 16'hFFFF.
- Reset mid-access aborts the access: strobes drop on the next edge, no ack is issued, and dato is left at its reset value.
- Requests arriving while busy wait; there is no queueing beyond the level req.

## Timing
- Let T be the IDLE cycle with the request sampled.
- ram_ce is high T+1..T+ACC_CYC.
- ram_we (writes) is high T+2..T+ACC_CYC-1.
- Ack and dato are valid at T+ACC_CYC+1.
- The earliest next grant is at T+ACC_CYC+RCV_CYC+1; the next ram_ce rises one cycle later.
- Defaults: ack at T+5; back-to-back access period 6 cycles.
- All outputs are registered; there is no combinational path from req to RAM strobes.

## Structure
- Package mem_arb_pkg holds:
  - the state enum (IDLE, CPU_ACC, DMA_ACC, RECOV);
  - the wait_ctr width;
  - the reset constants for the dato registers.
- Sub-module ram_cycle: a phase counter plus ce/oe/we generator. It takes start, we and ACC_CYC and outputs strobes and a last-phase pulse. The arbiter FSM instantiates it once.

## Test plan
- CPU read, cpu_addr=23'h000003, ram_dato=16'hA55A → ram_addr=22'h000001, ram_be=2'b10, ram_ce high for 4 cycles, cpu_ack at T+5, cpu_dato=8'hA5.
- CPU write, addr=23'h000010, dati=8'h3C → ram_be=2'b01, ram_dati=16'h3C3C, ram_we high exactly 2 cycles (T+2, T+3), no ram_oe.
- cpu_req and dma_req rise on the same cycle, wait_ctr=0 → CPU served first; DMA granted at T+6, its ack at T+11.
- CPU re-requests continuously while dma_req is held → DMA granted no later than the first IDLE after wait_ctr reaches 16; wait_ctr then reads 0.
- DMA write of 16'hBEEF to word 22'h3FFFFF → ram_be=2'b11, ram_addr=22'h3FFFFF, dma_ack after 5 cycles.
- rst asserted at phase 2 of a DMA read → next edge: ram_ce/oe/we=0, state IDLE, no dma_ack, dma_dato=16'hFFFF, busy=0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the cartridge RAM arbiter.
// Holds the FSM state encoding, the DMA wait counter width and the read-data reset values.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CPU_ACC = 2'd1,
        DMA_ACC = 2'd2,
        RECOV   = 2'd3
    } arb_state_t;

    localparam int WAIT_W = 6;

    localparam logic [7:0]  CPU_DATO_RST = 8'hFF;
    localparam logic [15:0] DMA_DATO_RST = 16'hFFFF;

endpackage

// File: rtl/mem_arb_ram_cycle.sv
// One RAM access: phase counter 0..ACC_CYC-1 driving registered ce/oe/we strobes.
// Strobes rise on the edge that samples start; last flags the final phase.
module ram_cycle #(
    parameter int ACC_CYC = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic we,
    output logic ce,
    output logic oe,
    output logic we_stb,
    output logic last
);

    localparam int PH_W = (ACC_CYC > 2) ? $clog2(ACC_CYC) : 1;

    logic [PH_W-1:0] phase;
    logic            active;
    logic            wr;

    assign last = active && (phase == PH_W'(ACC_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            active <= 1'b0;
            phase  <= '0;
            wr     <= 1'b0;
            ce     <= 1'b0;
            oe     <= 1'b0;
            we_stb <= 1'b0;
        end else if (start) begin
            active <= 1'b1;
            phase  <= '0;
            wr     <= we;
            ce     <= 1'b1;
            oe     <= !we;
            we_stb <= 1'b0;
        end else if (active) begin
            if (last) begin
                active <= 1'b0;
                phase  <= '0;
                ce     <= 1'b0;
                oe     <= 1'b0;
                we_stb <= 1'b0;
            end else begin
                phase  <= phase + 1'b1;
                // we covers phases 1..ACC_CYC-2: one setup and one hold phase around it
                we_stb <= wr && (int'(phase) < ACC_CYC - 2);
            end
        end
    end

endmodule

// File: rtl/mem_arb.sv
// Two-port arbiter for the 16-bit cartridge RAM: CPU byte path vs. DMA word path.
// CPU wins by default; a saturating wait counter forces a DMA grant after DMA_MAX_WAIT cycles.
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int ACC_CYC      = 4,
    parameter int RCV_CYC      = 1,
    parameter int DMA_MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [22:0] cpu_addr,
    input  logic [7:0]  cpu_dati,
    output logic [7:0]  cpu_dato,
    output logic        cpu_ack,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [21:0] dma_addr,
    input  logic [15:0] dma_dati,
    output logic [15:0] dma_dato,
    output logic        dma_ack,
    output logic [21:0] ram_addr,
    output logic [15:0] ram_dati,
    input  logic [15:0] ram_dato,
    output logic        ram_ce,
    output logic        ram_oe,
    output logic        ram_we,
    output logic [1:0]  ram_be,
    output logic        busy
);

    localparam int RC_W = (RCV_CYC > 1) ? $clog2(RCV_CYC) : 1;

    arb_state_t        state;
    logic [WAIT_W-1:0] wait_ctr;
    logic [RC_W-1:0]   rcv_ctr;
    logic              dma_own;
    logic              lat_we;
    logic              lat_hi;
    logic              grant_dma;
    logic              grant_cpu;
    logic              dma_in_service;
    logic              acc_last;

    assign grant_dma = (state == IDLE) && dma_req &&
                       ((wait_ctr >= WAIT_W'(DMA_MAX_WAIT)) || !cpu_req);
    assign grant_cpu = (state == IDLE) && cpu_req && !grant_dma;

    // The DMA stops accruing wait time once it owns the RAM, including its recovery.
    assign dma_in_service = (state == DMA_ACC) || ((state == RECOV) && dma_own);

    ram_cycle #(
        .ACC_CYC (ACC_CYC)
    ) u_cycle (
        .clk    (clk),
        .rst    (rst),
        .start  (grant_dma || grant_cpu),
        .we     (grant_dma ? dma_we : cpu_we),
        .ce     (ram_ce),
        .oe     (ram_oe),
        .we_stb (ram_we),
        .last   (acc_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            wait_ctr <= '0;
            rcv_ctr  <= '0;
            dma_own  <= 1'b0;
            lat_we   <= 1'b0;
            lat_hi   <= 1'b0;
            cpu_ack  <= 1'b0;
            dma_ack  <= 1'b0;
            busy     <= 1'b0;
            ram_be   <= 2'b00;
            cpu_dato <= CPU_DATO_RST;
            dma_dato <= DMA_DATO_RST;
        end else begin
            cpu_ack <= 1'b0;
            dma_ack <= 1'b0;

            if (grant_dma) begin
                wait_ctr <= '0;
            end else if (dma_req && !dma_in_service && (wait_ctr != '1)) begin
                wait_ctr <= wait_ctr + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (grant_dma) begin
                        state   <= DMA_ACC;
                        busy    <= 1'b1;
                        dma_own <= 1'b1;
                        lat_we  <= dma_we;
                        ram_be  <= 2'b11;
                    end else if (grant_cpu) begin
                        state   <= CPU_ACC;
                        busy    <= 1'b1;
                        dma_own <= 1'b0;
                        lat_we  <= cpu_we;
                        lat_hi  <= cpu_addr[0];
                        ram_be  <= cpu_addr[0] ? 2'b10 : 2'b01;
                    end
                end
                CPU_ACC: begin
                    if (acc_last) begin
                        if (!lat_we) begin
                            cpu_dato <= lat_hi ? ram_dato[15:8] : ram_dato[7:0];
                        end
                        cpu_ack <= 1'b1;
                        rcv_ctr <= '0;
                        state   <= RECOV;
                    end
                end
                DMA_ACC: begin
                    if (acc_last) begin
                        if (!lat_we) begin
                            dma_dato <= ram_dato;
                        end
                        dma_ack <= 1'b1;
                        rcv_ctr <= '0;
                        state   <= RECOV;
                    end
                end
                RECOV: begin
                    if (rcv_ctr == RC_W'(RCV_CYC - 1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        rcv_ctr <= rcv_ctr + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Address and write data only matter while ce is high, so they carry no reset.
    always_ff @(posedge clk) begin
        if (grant_dma) begin
            ram_addr <= dma_addr;
            ram_dati <= dma_dati;
        end else if (grant_cpu) begin
            ram_addr <= cpu_addr[22:1];
            ram_dati <= {cpu_dati, cpu_dati};
        end
    end

endmodule
